srv_mem_arbiter: RTL and testbench

SRV_MEM_ARBITER -- requirements
Module: srv_mem_arbiter

---
 rtl/srv_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_srv_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srv_mem_arbiter.sv
// Two-port round-robin memory refill arbiter.
// Port 0 (instruction refill) and port 1 (data refill) share one downstream
// memory controller. One transaction is in flight at a time. A BUSY-cycle
// counter aborts a transaction that never receives a downstream response.
module srv_mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LINE_W  = 128,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    output logic              rsp0_o,
    output logic [LINE_W-1:0] data0_o,
    input  logic              req1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    output logic              rsp1_o,
    output logic [LINE_W-1:0] data1_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] ext_addr_o,
    output logic              ext_req_o,
    input  logic              ext_rsp_i,
    input  logic [LINE_W-1:0] ext_data_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic              r_winner;    // 0: port 0, 1: port 1
    logic              r_last;      // last port served
    logic              r_err;       // current transaction timed out
    logic [7:0]        r_cnt;       // BUSY cycles elapsed, minus one
    logic [ADDR_W-1:0] r_ext_addr;
    logic [LINE_W-1:0] r_data0;
    logic [LINE_W-1:0] r_data1;

    logic              w_any_req;
    logic              w_grant;
    logic              w_timeout;

    // Round-robin pick: lone requester wins, a tie goes to the port not served last.
    always_comb begin
        w_any_req = req0_i | req1_i;
        if (req0_i && req1_i) begin
            w_grant = ~r_last;
        end else begin
            w_grant = req1_i;
        end
        // True in the TIMEOUT-th BUSY cycle.
        w_timeout = (r_cnt == 8'(TIMEOUT - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_any_req) w_state_next = StBusy;
            StBusy:  if (ext_rsp_i || w_timeout) w_state_next = StResp;
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Datapath: grant capture, BUSY counter, line capture and last-served update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_winner   <= 1'b0;
            r_last     <= 1'b1;
            r_err      <= 1'b0;
            r_cnt      <= 8'd0;
            r_ext_addr <= '0;
            r_data0    <= '0;
            r_data1    <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_any_req) begin
                        r_winner   <= w_grant;
                        r_ext_addr <= w_grant ? addr1_i : addr0_i;
                        r_cnt      <= 8'd0;
                        r_err      <= 1'b0;
                    end
                end
                StBusy: begin
                    r_cnt <= r_cnt + 8'd1;
                    // A response arriving on the timeout cycle still wins.
                    if (ext_rsp_i) begin
                        r_err <= 1'b0;
                        if (r_winner) r_data1 <= ext_data_i;
                        else          r_data0 <= ext_data_i;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                        if (r_winner) r_data1 <= '0;
                        else          r_data0 <= '0;
                    end
                end
                StResp: begin
                    r_last <= r_winner;
                end
                default: ;
            endcase
        end
    end

    assign ext_req_o  = (r_state == StBusy);
    assign ext_addr_o = r_ext_addr;
    assign busy_o     = (r_state != StIdle);
    assign rsp0_o     = (r_state == StResp) && !r_winner;
    assign rsp1_o     = (r_state == StResp) && r_winner;
    assign err_o      = (r_state == StResp) && r_err;
    assign data0_o    = r_data0;
    assign data1_o    = r_data1;

endmodule

// File: tb/tb_srv_mem_arbiter.sv
// Self-checking bench for srv_mem_arbiter. The bench plays the downstream
// memory controller and predicts each transaction from the arbitration and
// timeout rules: who wins, how long ext_req_o stays up, and what line and
// error flag the winner gets back.
module tb_srv_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 128;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic          rsp0_o, rsp1_o, err_o, ext_req_o, busy_o;
    logic [LW-1:0] data0_o, data1_o;
    logic [AW-1:0] ext_addr_o;
    logic          ext_rsp_i = 1'b0;
    logic [LW-1:0] ext_data_i = '0;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: last port served and each port's line register.
    bit            m_last = 1'b1;
    logic [LW-1:0] m_data0 = '0, m_data1 = '0;

    srv_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_i(req0), .addr0_i(addr0), .rsp0_o(rsp0_o), .data0_o(data0_o),
        .req1_i(req1), .addr1_i(addr1), .rsp1_o(rsp1_o), .data1_o(data1_o),
        .err_o(err_o), .ext_addr_o(ext_addr_o), .ext_req_o(ext_req_o),
        .ext_rsp_i(ext_rsp_i), .ext_data_i(ext_data_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One full transaction starting from IDLE with requests already applied.
    // d: BUSY cycle (1-based) carrying ext_rsp_i; 0 means no response ever.
    task automatic run_txn(input int d, input bit drop_w, input string tag, output bit w);
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] line;
        bit            timed;
        int            len;
        if (req0 && req1) w = ~m_last;
        else              w = req1;
        exp_addr = w ? addr1 : addr0;
        line     = rand_line();
        timed    = (d == 0) || (d > int'(TO));
        len      = timed ? int'(TO) : d;
        tick;
        for (int i = 1; i <= len; i++) begin
            n_cmp++;
            if ({busy_o, ext_req_o, rsp0_o, rsp1_o} !== 4'b1100 || ext_addr_o !== exp_addr) begin
                n_bad++;
                $display("FAIL %s busy cyc%0d: busy/req/rsp0/rsp1=%b addr=%h, want 1100 addr=%h",
                         tag, i, {busy_o, ext_req_o, rsp0_o, rsp1_o}, ext_addr_o, exp_addr);
            end
            if (drop_w && i == 1) begin
                if (w) req1 = 1'b0;
                else   req0 = 1'b0;
            end
            if (i == d) begin
                ext_rsp_i  = 1'b1;
                ext_data_i = line;
            end
            tick;
            ext_rsp_i  = 1'b0;
            ext_data_i = rand_line();   // junk without ext_rsp_i must be ignored
        end
        if (w) m_data1 = timed ? '0 : line;
        else   m_data0 = timed ? '0 : line;
        n_cmp++;
        if ({busy_o, ext_req_o, rsp0_o, rsp1_o, err_o} !== {1'b1, 1'b0, ~w, w, timed}) begin
            n_bad++;
            $display("FAIL %s resp: busy/req/rsp0/rsp1/err=%b, want %b", tag,
                     {busy_o, ext_req_o, rsp0_o, rsp1_o, err_o}, {1'b1, 1'b0, ~w, w, timed});
        end
        n_cmp++;
        if (data0_o !== m_data0 || data1_o !== m_data1) begin
            n_bad++;
            $display("FAIL %s resp data: d0=%h d1=%h, want d0=%h d1=%h",
                     tag, data0_o, data1_o, m_data0, m_data1);
        end
        // Stray downstream response during RESP.
        ext_rsp_i  = 1'b1;
        ext_data_i = rand_line();
        m_last     = w;
        tick;
        ext_rsp_i  = 1'b0;
        n_cmp++;
        if ({busy_o, ext_req_o, rsp0_o, rsp1_o, err_o} !== 5'b0 ||
            data0_o !== m_data0 || data1_o !== m_data1) begin
            n_bad++;
            $display("FAIL %s idle: busy/req/rsp0/rsp1/err=%b d0=%h d1=%h, want 00000 d0=%h d1=%h",
                     tag, {busy_o, ext_req_o, rsp0_o, rsp1_o, err_o}, data0_o, data1_o,
                     m_data0, m_data1);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        m_last  = 1'b1;
        m_data0 = '0;
        m_data1 = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        n_cmp++;
        if ({busy_o, ext_req_o, rsp0_o, rsp1_o, err_o} !== 5'b0 || ext_addr_o !== '0 ||
            data0_o !== '0 || data1_o !== '0) begin
            n_bad++;
            $display("FAIL reset: ctl=%b addr=%h d0=%h d1=%h, want all zero",
                     {busy_o, ext_req_o, rsp0_o, rsp1_o, err_o}, ext_addr_o, data0_o, data1_o);
        end
        rst = 1'b0;
        ext_rsp_i = 1'b1;   // stray response in IDLE
        tick;
        ext_rsp_i = 1'b0;
        n_cmp++;
        if ({busy_o, rsp0_o, rsp1_o} !== 3'b0 || data0_o !== '0) begin
            n_bad++;
            $display("FAIL idle_stray: busy/rsp0/rsp1=%b d0=%h, want 000 d0=0",
                     {busy_o, rsp0_o, rsp1_o}, data0_o);
        end
    endtask

    task automatic test_single_req0;
        bit w;
        req0  = 1'b1;
        addr0 = 32'h40;
        addr1 = $urandom;
        run_txn(4, 1'b0, "single_req0", w);
        req0 = 1'b0;
        n_cmp++;
        if (w !== 1'b0 || data0_o !== {16{8'hA5}} && m_data0 === {16{8'hA5}}) begin
            n_bad++;
            $display("FAIL single_req0 winner: got %0d, want 0", w);
        end
        // Fixed-pattern line through port 0.
        req0 = 1'b1;
        begin
            logic [LW-1:0] pat;
            pat = {16{8'hA5}};
            tick;
            tick; tick; tick;
            ext_rsp_i = 1'b1; ext_data_i = pat;
            tick;
            ext_rsp_i = 1'b0;
            req0 = 1'b0;
            m_data0 = pat;
            m_last  = 1'b0;
            n_cmp++;
            if ({rsp0_o, rsp1_o, err_o} !== 3'b100 || data0_o !== pat || ext_addr_o !== 32'h40) begin
                n_bad++;
                $display("FAIL pattern_a5: rsp0/rsp1/err=%b d0=%h addr=%h, want 100 d0=%h addr=40",
                         {rsp0_o, rsp1_o, err_o}, data0_o, ext_addr_o, pat);
            end
            tick;
        end
    endtask

    task automatic test_round_robin;
        bit w;
        bit [3:0] seq;
        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = $urandom;
        addr1 = $urandom;
        do_reset;
        for (int i = 0; i < 4; i++) begin
            run_txn(int'($urandom_range(1, 3)), 1'b0, "round_robin", w);
            seq[i] = w;
        end
        n_cmp++;
        if (seq !== 4'b1010) begin
            n_bad++;
            $display("FAIL rr_order: grants (lsb first)=%b, want 1010", seq);
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_timeout;
        bit w;
        req1  = 1'b1;
        addr1 = $urandom;
        run_txn(0, 1'b0, "timeout", w);
        run_txn(int'(TO), 1'b0, "rsp_at_timeout", w);
        run_txn(int'(TO) + 1, 1'b0, "rsp_after_timeout", w);
        req1 = 1'b0;
    endtask

    task automatic test_reset_mid_busy;
        req0  = 1'b1;
        addr0 = $urandom;
        tick;
        tick;
        rst  = 1'b1;
        req0 = 1'b0;
        tick;
        rst = 1'b0;
        m_last = 1'b1; m_data0 = '0; m_data1 = '0;
        n_cmp++;
        if ({busy_o, ext_req_o, rsp0_o, rsp1_o, err_o} !== 5'b0 || ext_addr_o !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_busy: ctl=%b addr=%h, want 00000 addr=0",
                     {busy_o, ext_req_o, rsp0_o, rsp1_o, err_o}, ext_addr_o);
        end
        ext_rsp_i  = 1'b1;
        ext_data_i = rand_line();
        tick;
        ext_rsp_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({busy_o, ext_req_o, rsp0_o, rsp1_o, err_o} !== 5'b0 ||
                data0_o !== '0 || data1_o !== '0) begin
                n_bad++;
                $display("FAIL late_rsp cyc%0d: ctl=%b d0=%h d1=%h, want all zero",
                         i, {busy_o, ext_req_o, rsp0_o, rsp1_o, err_o}, data0_o, data1_o);
            end
            tick;
        end
    endtask

    task automatic test_drop_req;
        bit w;
        req0 = 1'b0;
        req1 = 1'b1;
        addr1 = $urandom;
        run_txn(2, 1'b1, "drop_req1", w);
        req0 = 1'b1;
        req1 = 1'b1;
        addr0 = $urandom;
        run_txn(1, 1'b0, "tie_after_drop", w);
        n_cmp++;
        if (w !== 1'b0) begin
            n_bad++;
            $display("FAIL tie_after_drop winner: got %0d, want 0", w);
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_random;
        bit w;
        for (int i = 0; i < 25; i++) begin
            int r;
            r = int'($urandom_range(1, 3));
            req0 = r[0];
            req1 = r[1];
            if ($urandom_range(0, 1) == 1) addr0 = $urandom;
            if ($urandom_range(0, 1) == 1) addr1 = $urandom;
            run_txn(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), "random", w);
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single_req0;
        test_round_robin;
        test_timeout;
        test_reset_mid_busy;
        test_drop_req;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
